// File: rtl/ad9866_pkg.sv
// Shared definitions for the AD9866 serial-port sequencer: frame layout,
// default gain register address, sequencer state encoding and a frame helper.
package ad9866_pkg;

    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    localparam logic [6:0] GAIN_ADDR_DEFAULT = 7'h09;

    // Frame phases: 0 = setup, 1..32 = alternating sclk low/high halves, 33 = hold
    localparam logic [5:0] PHASE_LAST = 6'd33;

    typedef enum logic [2:0] {
        ST_RST_HOLD,
        ST_RST_WAIT,
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    // Pack {rw, addr, data} into an MSB-first serial frame word
    function automatic logic [FRAME_W-1:0] make_frame(input logic rw,
                                                      input logic [6:0] addr,
                                                      input logic [7:0] data);
        logic [FRAME_W-1:0] w;
        w = '0;
        w[RW_BIT]            = rw;
        w[ADDR_MSB:ADDR_LSB] = addr;
        w[DATA_MSB:0]        = data;
        return w;
    endfunction

endpackage

// File: rtl/ad9866_init_rom.sv
// Power-up register table for the AD9866, streamed after the hardware reset.
// Entries at or beyond INIT_LEN read back as zero.
module ad9866_init_rom import ad9866_pkg::*; #(
    parameter int INIT_LEN = 8
) (
    input  logic [4:0]         idx,
    output logic [FRAME_W-1:0] word
);

    // Index to table word; all entries are register writes
    always_comb begin
        word = '0;
        if (int'(idx) < INIT_LEN) begin
            case (idx)
                5'd0:    word = make_frame(1'b0, 7'h00, 8'h80);
                5'd1:    word = make_frame(1'b0, 7'h01, 8'h40);
                5'd2:    word = make_frame(1'b0, 7'h02, 8'h81);
                5'd3:    word = make_frame(1'b0, 7'h03, 8'h00);
                5'd4:    word = make_frame(1'b0, 7'h04, 8'h05);
                5'd5:    word = make_frame(1'b0, 7'h07, 8'h20);
                5'd6:    word = make_frame(1'b0, 7'h08, 8'h21);
                5'd7:    word = make_frame(1'b0, 7'h0E, 8'h81);
                default: word = '0;
            endcase
        end
    end

endmodule

// File: rtl/ad9866_spi_seq.sv
// AD9866 serial control port sequencer: hardware reset pulse, init table
// playback, then arbitration between host register accesses and RX gain updates.
module ad9866_spi_seq import ad9866_pkg::*; #(
    parameter int         SPI_DIV    = 4,
    parameter int         RST_CYCLES = 64,
    parameter int         RST_WAIT   = 256,
    parameter int         INIT_LEN   = 8,
    parameter logic [6:0] GAIN_ADDR  = GAIN_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_valid,
    output logic       host_ready,
    input  logic       host_rw,
    input  logic [6:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    input  logic       gain_valid,
    input  logic [5:0] gain,
    output logic       init_done,
    output logic       busy,
    output logic       ad9866_rst_n,
    output logic       ad9866_sen_n,
    output logic       ad9866_sclk,
    output logic       ad9866_sdio,
    input  logic       ad9866_sdo
);

    localparam logic [15:0] DIV_LAST  = 16'(SPI_DIV - 1);
    localparam logic [15:0] HOLD_LAST = 16'(RST_CYCLES - 1);
    // One cycle of the wait is spent in INIT dispatching the first word
    localparam logic [15:0] WAIT_LAST = 16'(RST_WAIT - 2);

    state_t             state_reg, state_next;
    logic [15:0]        cnt_reg, cnt_next;
    logic [5:0]         phase_reg, phase_next;
    logic [FRAME_W-1:0] frame_reg, frame_next;
    logic               is_read_reg, is_read_next;
    logic [5:0]         init_idx_reg, init_idx_next;
    logic               init_done_reg, init_done_next;
    logic               last_host_reg, last_host_next;
    logic               gain_pend_reg, gain_pend_next;
    logic [5:0]         gain_val_reg, gain_val_next;
    logic [7:0]         rx_reg, rx_next;
    logic [7:0]         rd_data_reg, rd_data_next;
    logic               rd_valid_reg, rd_valid_next;
    logic               rst_n_reg, rst_n_next;
    logic               sen_n_reg, sen_n_next;
    logic               sclk_reg, sclk_next;
    logic               sdio_reg, sdio_next;

    logic [FRAME_W-1:0] rom_word;
    logic               gain_first;
    logic               host_fire;
    logic               start_gain;
    logic [3:0]         bit_idx;

    ad9866_init_rom #(.INIT_LEN(INIT_LEN)) u_rom (
        .idx  (init_idx_reg[4:0]),
        .word (rom_word)
    );

    // Arbitration: a pending gain goes first when the host is idle or just had a frame
    always_comb begin
        gain_first = gain_pend_reg && (last_host_reg || !host_valid);
        host_ready = (state_reg == ST_IDLE) && init_done_reg && !gain_first;
        host_fire  = host_valid && host_ready;
    end

    // Next-state, datapath and pin decode; pins are registered from next values
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        phase_next     = phase_reg;
        frame_next     = frame_reg;
        is_read_next   = is_read_reg;
        init_idx_next  = init_idx_reg;
        init_done_next = init_done_reg;
        last_host_next = last_host_reg;
        gain_pend_next = gain_pend_reg;
        gain_val_next  = gain_val_reg;
        rx_next        = rx_reg;
        rd_data_next   = rd_data_reg;
        rd_valid_next  = 1'b0;
        start_gain     = 1'b0;

        case (state_reg)
            ST_RST_HOLD: begin
                if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_RST_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_RST_WAIT: begin
                if (cnt_reg == WAIT_LAST) begin
                    state_next = ST_INIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_INIT: begin
                if (init_idx_reg == 6'(INIT_LEN)) begin
                    state_next     = ST_IDLE;
                    init_done_next = 1'b1;
                end else begin
                    frame_next    = rom_word;
                    is_read_next  = 1'b0;
                    init_idx_next = init_idx_reg + 6'd1;
                    state_next    = ST_SHIFT;
                    cnt_next      = '0;
                    phase_next    = '0;
                end
            end
            ST_IDLE: begin
                if (host_fire) begin
                    frame_next     = make_frame(host_rw, host_addr, host_rw ? 8'h00 : host_wdata);
                    is_read_next   = host_rw;
                    last_host_next = 1'b1;
                    state_next     = ST_SHIFT;
                    cnt_next       = '0;
                    phase_next     = '0;
                end else if (gain_pend_reg) begin
                    frame_next     = make_frame(1'b0, GAIN_ADDR, {2'b01, gain_val_reg});
                    is_read_next   = 1'b0;
                    last_host_next = 1'b0;
                    start_gain     = 1'b1;
                    state_next     = ST_SHIFT;
                    cnt_next       = '0;
                    phase_next     = '0;
                end
            end
            ST_SHIFT: begin
                // sdo is taken in the first clk of each sclk-high phase
                if (cnt_reg == '0 && !phase_reg[0] && phase_reg >= 6'd2) begin
                    rx_next = {rx_reg[6:0], ad9866_sdo};
                end
                if (cnt_reg == DIV_LAST) begin
                    cnt_next = '0;
                    if (phase_reg == PHASE_LAST) begin
                        state_next = ST_GAP;
                        phase_next = '0;
                        if (is_read_reg) begin
                            rd_valid_next = 1'b1;
                            rd_data_next  = rx_reg;
                        end
                    end else begin
                        phase_next = phase_reg + 6'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            ST_GAP: begin
                if (cnt_reg == DIV_LAST) begin
                    cnt_next   = '0;
                    state_next = init_done_reg ? ST_IDLE : ST_INIT;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            default: state_next = ST_RST_HOLD;
        endcase

        // Gain updates coalesce; a new strobe wins over the clear on frame start
        if (gain_valid) begin
            gain_pend_next = 1'b1;
            gain_val_next  = gain;
        end else if (start_gain) begin
            gain_pend_next = 1'b0;
        end

        bit_idx    = 4'((phase_next - 6'd1) >> 1);
        rst_n_next = (state_next != ST_RST_HOLD);
        sen_n_next = (state_next != ST_SHIFT);
        sclk_next  = (state_next == ST_SHIFT) && (phase_next >= 6'd2) &&
                     (phase_next <= 6'd32) && !phase_next[0];
        sdio_next  = 1'b0;
        if (state_next == ST_SHIFT) begin
            if (phase_next == PHASE_LAST) begin
                sdio_next = sdio_reg;
            end else if (phase_next != 6'd0) begin
                sdio_next = (is_read_next && bit_idx[3]) ? 1'b0 : frame_next[4'd15 - bit_idx];
            end
        end
    end

    // State and pin registers with asynchronous reset to the safe pin levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_RST_HOLD;
            cnt_reg       <= '0;
            phase_reg     <= '0;
            frame_reg     <= '0;
            is_read_reg   <= 1'b0;
            init_idx_reg  <= '0;
            init_done_reg <= 1'b0;
            last_host_reg <= 1'b0;
            gain_pend_reg <= 1'b0;
            gain_val_reg  <= '0;
            rx_reg        <= '0;
            rd_data_reg   <= '0;
            rd_valid_reg  <= 1'b0;
            rst_n_reg     <= 1'b0;
            sen_n_reg     <= 1'b1;
            sclk_reg      <= 1'b0;
            sdio_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_next;
            frame_reg     <= frame_next;
            is_read_reg   <= is_read_next;
            init_idx_reg  <= init_idx_next;
            init_done_reg <= init_done_next;
            last_host_reg <= last_host_next;
            gain_pend_reg <= gain_pend_next;
            gain_val_reg  <= gain_val_next;
            rx_reg        <= rx_next;
            rd_data_reg   <= rd_data_next;
            rd_valid_reg  <= rd_valid_next;
            rst_n_reg     <= rst_n_next;
            sen_n_reg     <= sen_n_next;
            sclk_reg      <= sclk_next;
            sdio_reg      <= sdio_next;
        end
    end

    assign init_done    = init_done_reg;
    assign busy         = (state_reg != ST_IDLE) | gain_pend_reg;
    assign rd_valid     = rd_valid_reg;
    assign rd_data      = rd_data_reg;
    assign ad9866_rst_n = rst_n_reg;
    assign ad9866_sen_n = sen_n_reg;
    assign ad9866_sclk  = sclk_reg;
    assign ad9866_sdio  = sdio_reg;

endmodule

// File: tb/tb_ad9866_spi_seq.sv
// Bench for ad9866_spi_seq: a bus monitor decodes serial frames from the pins,
// a simple AD9866 sdo model answers reads, and directed steps with random data
// compare decoded frames and handshakes against values computed here.
module tb_ad9866_spi_seq;

    localparam int SPI_DIV    = 4;
    localparam int RST_CYCLES = 64;
    localparam int RST_WAIT   = 256;
    localparam int INIT_LEN   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       host_valid = 1'b0;
    logic       host_ready;
    logic       host_rw = 1'b0;
    logic [6:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       gain_valid = 1'b0;
    logic [5:0] gain = '0;
    logic       init_done;
    logic       busy;
    logic       ad9866_rst_n;
    logic       ad9866_sen_n;
    logic       ad9866_sclk;
    logic       ad9866_sdio;
    logic       ad9866_sdo;

    always #5 clk = ~clk;

    ad9866_spi_seq #(
        .SPI_DIV(SPI_DIV), .RST_CYCLES(RST_CYCLES), .RST_WAIT(RST_WAIT),
        .INIT_LEN(INIT_LEN), .GAIN_ADDR(7'h09)
    ) dut (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_rw(host_rw),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .gain_valid(gain_valid), .gain(gain),
        .init_done(init_done), .busy(busy),
        .ad9866_rst_n(ad9866_rst_n), .ad9866_sen_n(ad9866_sen_n),
        .ad9866_sclk(ad9866_sclk), .ad9866_sdio(ad9866_sdio), .ad9866_sdo(ad9866_sdo)
    );

    typedef struct {
        logic [15:0] word;
        int          low_len;
        int          sclks;
        int          fall_cyc;
        int          rise_cyc;
        int          gap;
    } frame_t;

    frame_t fq[$];
    int vectors = 0;
    int miscompares = 0;

    // Cycle index: number of clk rising edges since reset was released
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Bus monitor state, sampled on the falling clk edge
    logic        prev_sen = 1'b1, prev_sclk = 1'b0, prev_rstn = 1'b0, prev_busy = 1'b1, prev_rdv = 1'b0;
    logic [15:0] cur_word = '0;
    int          cur_low = 0, cur_sclks = 0, cur_fall = 0, cur_gap = 0, gap_cnt = 0, mon_bits = 0;
    int          rstn_rise_cyc = -1, busy_fall_cyc = -1, rdv_cyc = -1, rdv_len = 0;
    logic [7:0]  rdv_data = '0;
    logic [7:0]  sdo_byte = '0;

    // Device model: shifts sdo_byte out during bits 8..15, one bit per sclk fall
    assign ad9866_sdo = (mon_bits >= 8 && mon_bits < 16) ? sdo_byte[3'(15 - mon_bits)] : 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_sen = 1'b1; prev_sclk = 1'b0; prev_rstn = 1'b0; prev_busy = 1'b1; prev_rdv = 1'b0;
            cur_low = 0; cur_sclks = 0; mon_bits = 0; gap_cnt = 0; cur_word = '0;
            rstn_rise_cyc = -1;
        end else begin
            if (!ad9866_sen_n) begin
                if (prev_sen) begin
                    cur_fall = cyc; cur_gap = gap_cnt; cur_low = 0; cur_sclks = 0;
                    cur_word = '0; mon_bits = 0;
                end
                cur_low++;
                if (ad9866_sclk && !prev_sclk) begin
                    cur_word = {cur_word[14:0], ad9866_sdio};
                    cur_sclks++;
                end
                if (!ad9866_sclk && prev_sclk) mon_bits++;
            end else if (!prev_sen) begin
                fq.push_back('{cur_word, cur_low, cur_sclks, cur_fall, cyc, cur_gap});
                gap_cnt = 1;
                mon_bits = 0;
            end else begin
                gap_cnt++;
            end
            if (!prev_rstn && ad9866_rst_n) rstn_rise_cyc = cyc;
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            if (rd_valid) begin
                if (!prev_rdv) begin
                    rdv_cyc = cyc; rdv_len = 0; rdv_data = rd_data;
                end
                rdv_len++;
            end
            prev_sen = ad9866_sen_n; prev_sclk = ad9866_sclk; prev_rstn = ad9866_rst_n;
            prev_busy = busy; prev_rdv = rd_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic get_frame(output frame_t f);
        int n = 0;
        while (fq.size() == 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_seen", 32'(fq.size() > 0), 32'd1);
        if (fq.size() > 0) f = fq.pop_front();
        else f = '{16'h0, 0, 0, 0, 0, 0};
    endtask

    task automatic host_req(input logic rw, input logic [6:0] a, input logic [7:0] d,
                            input logic with_gain, input logic [5:0] g);
        int n = 0;
        host_rw = rw; host_addr = a; host_wdata = d; host_valid = 1'b1;
        #1;
        while (!host_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("host_accept", 32'(host_ready), 32'd1);
        if (with_gain) begin
            gain = g; gain_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        host_valid = 1'b0;
        gain_valid = 1'b0;
    endtask

    // Expected power-up register writes
    logic [15:0] rom_exp [INIT_LEN] = '{16'h0080, 16'h0140, 16'h0281, 16'h0300,
                                        16'h0405, 16'h0720, 16'h0821, 16'h0E81};

    task automatic check_init();
        frame_t f;
        int n = 0;
        for (int i = 0; i < INIT_LEN; i++) begin
            get_frame(f);
            $display("init frame %0d: word=%04h low=%0d sclks=%0d fall=%0d gap=%0d",
                     i, f.word, f.low_len, f.sclks, f.fall_cyc, f.gap);
            chk("init_word", 32'(f.word), 32'(rom_exp[i]));
            chk("init_low_len", 32'(f.low_len), 32'(34 * SPI_DIV));
            chk("init_sclks", 32'(f.sclks), 32'd16);
            if (i == 0) chk("first_sen_fall_cyc", 32'(f.fall_cyc), 32'(RST_CYCLES + RST_WAIT));
            else        chk("init_gap_min", 32'(f.gap >= SPI_DIV), 32'd1);
        end
        chk("rst_n_rise_cyc", 32'(rstn_rise_cyc), 32'(RST_CYCLES));
        while (!init_done && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("init_done", 32'(init_done), 32'd1);
    endtask

    initial begin
        frame_t f, f2, f3;
        logic [5:0] g1, g2, g3;
        logic [6:0] a, a2;
        logic [7:0] d, d2;
        logic [15:0] gain_word;

        // Reset values while rst is held
        repeat (3) @(negedge clk);
        chk("rst_rst_n", 32'(ad9866_rst_n), 32'd0);
        chk("rst_sen_n", 32'(ad9866_sen_n), 32'd1);
        chk("rst_sclk", 32'(ad9866_sclk), 32'd0);
        chk("rst_sdio", 32'(ad9866_sdio), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;

        // Host requests are refused during the reset/init sequence
        repeat (10) @(negedge clk);
        host_valid = 1'b1; host_rw = 1'b0; host_addr = 7'h11; host_wdata = 8'h22;
        #1 chk("init_host_ready", 32'(host_ready), 32'd0);
        @(negedge clk);
        chk("init_host_ready2", 32'(host_ready), 32'd0);
        host_valid = 1'b0;

        // Two gain updates during init coalesce; the last one wins
        g1 = 6'($urandom_range(0, 63));
        g2 = 6'($urandom_range(0, 63));
        repeat (50) @(negedge clk);
        gain = g1; gain_valid = 1'b1;
        @(negedge clk);
        gain_valid = 1'b0;
        repeat (400) @(negedge clk);
        chk("init_busy", 32'(busy), 32'd1);
        gain = g2; gain_valid = 1'b1;
        @(negedge clk);
        gain_valid = 1'b0;

        check_init();

        gain_word = {1'b0, 7'h09, 2'b01, g2};
        get_frame(f);
        $display("gain frame: word=%04h expected=%04h", f.word, gain_word);
        chk("gain_word", 32'(f.word), 32'(gain_word));
        repeat (300) @(negedge clk);
        chk("gain_single_frame", 32'(fq.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Host writes: fixed case first, then random address/data
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 7'h05 : 7'($urandom_range(0, 127));
            d = (i == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
            host_req(1'b0, a, d, 1'b0, 6'd0);
            get_frame(f);
            repeat (SPI_DIV + 4) @(negedge clk);
            $display("write %0d: word=%04h expected=%04h busy_fall-rise=%0d",
                     i, f.word, {1'b0, a, d}, busy_fall_cyc - f.rise_cyc);
            chk("wr_word", 32'(f.word), 32'({1'b0, a, d}));
            chk("wr_low_len", 32'(f.low_len), 32'(34 * SPI_DIV));
            chk("wr_sclks", 32'(f.sclks), 32'd16);
            chk("wr_busy_fall", 32'(busy_fall_cyc - f.rise_cyc), 32'(SPI_DIV));
        end

        // Host reads: header on sdio, data returned by the device model
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 7'h1F : 7'($urandom_range(0, 127));
            sdo_byte = (i == 0) ? 8'h5C : 8'($urandom_range(0, 255));
            host_req(1'b1, a, 8'($urandom_range(0, 255)), 1'b0, 6'd0);
            get_frame(f);
            repeat (SPI_DIV + 4) @(negedge clk);
            $display("read %0d: word=%04h rd_data=%02h expected=%02h",
                     i, f.word, rdv_data, sdo_byte);
            chk("rd_frame", 32'(f.word), 32'({1'b1, a, 8'h00}));
            chk("rd_valid_cyc", 32'(rdv_cyc), 32'(f.rise_cyc));
            chk("rd_valid_len", 32'(rdv_len), 32'd1);
            chk("rd_data_pulse", 32'(rdv_data), 32'(sdo_byte));
            chk("rd_data_held", 32'(rd_data), 32'(sdo_byte));
        end

        // Host and gain in the same idle cycle: host, then gain, then the next host
        g3 = 6'($urandom_range(0, 63));
        a = 7'($urandom_range(0, 127)); d = 8'($urandom_range(0, 255));
        a2 = 7'($urandom_range(0, 127)); d2 = 8'($urandom_range(0, 255));
        host_req(1'b0, a, d, 1'b1, g3);
        host_req(1'b0, a2, d2, 1'b0, 6'd0);
        get_frame(f); get_frame(f2); get_frame(f3);
        $display("arbitration: %04h %04h %04h", f.word, f2.word, f3.word);
        chk("arb_host_first", 32'(f.word), 32'({1'b0, a, d}));
        chk("arb_gain_second", 32'(f2.word), 32'({1'b0, 7'h09, 2'b01, g3}));
        chk("arb_host_third", 32'(f3.word), 32'({1'b0, a2, d2}));
        chk("arb_gap_min", 32'(f3.gap >= SPI_DIV), 32'd1);

        // Asynchronous reset in the middle of a frame, then a full replay
        host_rw = 1'b0; host_addr = 7'($urandom_range(0, 127)); host_wdata = 8'($urandom_range(0, 255));
        host_valid = 1'b1;
        begin
            int n = 0;
            while (!(!ad9866_sen_n && cur_sclks == 7) && n < 3000) begin
                @(negedge clk);
                n++;
                if (!ad9866_sen_n) host_valid = 1'b0;
            end
            chk("mid_frame_reached", 32'(cur_sclks), 32'd7);
        end
        host_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("mid-frame reset: sen_n=%0b sclk=%0b rst_n=%0b", ad9866_sen_n, ad9866_sclk, ad9866_rst_n);
        chk("async_sen_n", 32'(ad9866_sen_n), 32'd1);
        chk("async_sclk", 32'(ad9866_sclk), 32'd0);
        chk("async_rst_n", 32'(ad9866_rst_n), 32'd0);
        chk("async_init_done", 32'(init_done), 32'd0);
        chk("async_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        fq.delete();
        #1 rst = 1'b0;
        check_init();
        repeat (300) @(negedge clk);
        chk("replay_no_extra_frames", 32'(fq.size()), 32'd0);
        chk("replay_idle_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/ad9866_spi_seq.md
Name: ad9866_spi_seq

Overview:
Sequencer that owns the AD9866 serial control port (sclk/sdio/sdo/sen_n) and its hardware reset pin.
- After reset: pulses ad9866_rst_n, then streams a fixed init table of register writes.
- Afterwards: arbitrates runtime accesses between a host command port (read/write) and a RX-gain update port.
- Sits inside hermes_lite_core, clocked by the SPI/IF clock, between the command decoder and the AD9866 pins.

Parameters:
SPI_DIV, 4, clk cycles per sclk half-period; also setup/hold/gap unit; legal range 2..255
RST_CYCLES, 64, clk cycles ad9866_rst_n held low after reset release
RST_WAIT, 256, clk cycles after ad9866_rst_n rises before the first frame
INIT_LEN, 8, number of 16-bit words in the init table (1..32)
GAIN_ADDR, 7'h09, register address written by the gain port

Ports:
clk  in  1  sequencer clock
rst  in  1  asynchronous, active-high reset
host_valid  in  1  host request valid
host_ready  out  1  host request accepted this cycle when valid&ready
host_rw  in  1  1=read, 0=write
host_addr  in  7  register address
host_wdata  in  8  write data
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  8  read data, held until next read completes
gain_valid  in  1  gain update strobe
gain  in  6  RX PGA gain code
init_done  out  1  high once init table complete, stays high until rst
busy  out  1  high while a frame is in flight or a request is pending
ad9866_rst_n  out  1  AD9866 hardware reset
ad9866_sen_n  out  1  serial enable, active low
ad9866_sclk  out  1  serial clock, idle low
ad9866_sdio  out  1  serial data out
ad9866_sdo  in  1  serial data in

Behaviour:
- Reset values: ad9866_rst_n=0, sen_n=1, sclk=0, sdio=0, host_ready=0, rd_valid=0, rd_data=0, init_done=0, busy=1; FSM=RST_HOLD; gain pending flag cleared.
- Frame format: 16 bits, MSB first, {rw, addr[6:0], data[7:0]}.
- Frame timing:
  - sen_n falls, then SPI_DIV cycles setup.
  - 16 bit periods, each sclk low for SPI_DIV, then high for SPI_DIV; sdio is updated on entry to the low phase.
  - After the 16th high phase: sclk low, SPI_DIV hold cycles, then sen_n rises.
  - sen_n is low for exactly 34*SPI_DIV cycles (136 at default).
  - Minimum sen_n high gap of SPI_DIV cycles between frames.
- Reads:
  - sdio drives 0 during bits 8..15.
  - sdo is sampled on the clk cycle where sclk rises, for bits 8..15.
  - rd_valid pulses in the cycle after sen_n rises.
- FSM states:
  - RST_HOLD (RST_CYCLES) -> RST_WAIT (rst_n=1, RST_WAIT cycles) -> INIT (issue table words 0..INIT_LEN-1, index counter wraps never) -> IDLE.
  - IDLE -> SHIFT when any request is pending; SHIFT -> GAP -> IDLE.
  - init_done rises on the cycle INIT enters IDLE.
- host_ready:
  - High only in IDLE with init_done=1 and no frame starting from the gain port.
  - Request fields are captured on accept; the frame starts on the next cycle.
- Gain port:
  - gain_valid is accepted in any state, including init.
  - Latches gain and sets gain_pend; a new gain_valid while pending overwrites the value (coalesce, last wins).
  - Frame = write GAIN_ADDR, data {2'b01, gain}.
  - gain_pend clears when that frame starts; a gain_valid arriving in the same cycle re-sets it with the new value.
- Arbitration in IDLE:
  - Host has priority over a pending gain.
  - After a host frame, if gain is pending it is serviced before the next host accept (no starvation).
- busy = (FSM != IDLE) | gain_pend.
- Reset mid-frame: asynchronous return to reset values immediately; the AD9866 is re-reset and the init table is replayed.
- host_valid during init: ignored (host_ready=0); no drop, the requester must hold its request.

Decomposition:
- Shared package ad9866_pkg: frame width (16), field positions, GAIN_ADDR default, state enum.
- Sub-module ad9866_init_rom: combinational index -> 16-bit word table (INIT_LEN entries).
- Main module: FSM, arbiter, divider counter, shift register.

Test Plan:
- Reset release, SPI_DIV=4, RST_CYCLES=64, RST_WAIT=256 -> rst_n rises at cycle 64; first sen_n fall at cycle 320; 8 frames of 136 low cycles each with >=4-cycle gaps; init_done after frame 8; bits match the ROM.
- Host write addr 0x05, data 0xA3 after init -> host_ready handshake; bus shows 0x05A3 MSB first; 16 sclk rising edges; busy falls 4 cycles after sen_n rises.
- Host read addr 0x1F with sdo model returning 0x5C -> frame header 0x9F on sdio; rd_valid 1-cycle pulse with rd_data=0x5C.
- gain_valid with 0x10 then 0x2A during init -> exactly one gain frame after init_done, word 0x096A.
- host_valid and gain_valid in the same IDLE cycle -> host frame first, then gain frame; a second host request is held off until the gain frame completes.
- Assert rst at sclk edge 7 of a frame -> same cycle (async) sen_n=1, sclk=0, rst_n=0; full reset/init sequence replays.
